// File: rtl/gray_decoder_pkg.sv
// Shared definitions for the Gray-code decoder: FSM state encodings and
// the default word width reused by the encoder side and the testbench.
package gray_decoder_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    LOCKED = 2'd1,
    FAULT  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 3;

endpackage

// File: rtl/gray_decoder_gray2bin.sv
// Purely combinational Gray-to-binary conversion (XOR prefix from the MSB).
module gray2bin #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin = '0;
    bin[WIDTH-1] = gray[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
  end

endmodule

// File: rtl/gray_decoder.sv
// Receive-side Gray-code decoder: decodes each sample, enforces that the
// stream only holds or advances by one, and counts max->0 wrap-arounds.
module gray_decoder
  import gray_decoder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int WRAP_W = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              In_valid,
  input  logic [WIDTH-1:0]  Gray_in,
  output logic [WIDTH-1:0]  Bin_out,
  output logic              Out_valid,
  output logic [WRAP_W-1:0] Wraps,
  output logic              Locked,
  output logic              Error
);

  localparam logic [WIDTH-1:0]  MAX_VAL  = '1;
  localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

  state_t           state;
  logic [WIDTH-1:0] dec;
  logic [WIDTH-1:0] next_val;
  logic             is_hold;
  logic             is_next;
  logic             is_wrap;

  gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
    .gray (Gray_in),
    .bin  (dec)
  );

  // Legality compare against the last accepted value; p+1 wraps in WIDTH bits.
  always_comb begin
    next_val = Bin_out + WIDTH'(1);
    is_hold  = (dec == Bin_out);
    is_next  = (dec == next_val);
    is_wrap  = (Bin_out == MAX_VAL) && (dec == '0);
  end

  // Decoder FSM with all outputs registered; FAULT is only left through Reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= HUNT;
      Bin_out   <= '0;
      Out_valid <= 1'b0;
      Wraps     <= '0;
      Locked    <= 1'b0;
      Error     <= 1'b0;
    end else begin
      Out_valid <= 1'b0;
      if (In_valid) begin
        case (state)
          HUNT: begin
            Bin_out   <= dec;
            Out_valid <= 1'b1;
            Locked    <= 1'b1;
            state     <= LOCKED;
          end
          LOCKED: begin
            if (is_hold || is_next) begin
              Bin_out   <= dec;
              Out_valid <= 1'b1;
              if (is_wrap && (Wraps != WRAP_MAX)) begin
                Wraps <= Wraps + WRAP_W'(1);
              end
            end else begin
              Error  <= 1'b1;
              Locked <= 1'b0;
              state  <= FAULT;
            end
          end
          FAULT: begin
            state <= FAULT;
          end
          default: begin
            state <= HUNT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gray_decoder.sv
// Directed self-checking bench for gray_decoder (WIDTH=3, WRAP_W=4).
module tb_gray_decoder;
  import gray_decoder_pkg::*;

  localparam int WIDTH  = DEFAULT_WIDTH;
  localparam int WRAP_W = 4;

  logic              Clk;
  logic              Reset;
  logic              In_valid;
  logic [WIDTH-1:0]  Gray_in;
  logic [WIDTH-1:0]  Bin_out;
  logic              Out_valid;
  logic [WRAP_W-1:0] Wraps;
  logic              Locked;
  logic              Error;

  int n_cmp;
  int n_fail;

  // Gray sequence 000,001,011,010,110,111,101,100; index i decodes to binary i.
  logic [2:0] gtab [8];

  gray_decoder #(.WIDTH(WIDTH), .WRAP_W(WRAP_W)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .In_valid  (In_valid),
    .Gray_in   (Gray_in),
    .Bin_out   (Bin_out),
    .Out_valid (Out_valid),
    .Wraps     (Wraps),
    .Locked    (Locked),
    .Error     (Error)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic r, input logic v, input logic [2:0] g);
    Reset    = r;
    In_valid = v;
    Gray_in  = g;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 3'b000);
    step(1'b1, 1'b0, 3'b000);
    n_cmp++;
    if (Bin_out !== 3'd0 || Out_valid !== 1'b0 || Wraps !== 4'd0 ||
        Locked !== 1'b0 || Error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got bin=%0d ov=%b wraps=%0d lk=%b err=%b, need 0 0 0 0 0",
               Bin_out, Out_valid, Wraps, Locked, Error);
    end
    n_cmp++;
    if (dut.state !== HUNT) begin
      n_fail++;
      $display("FAIL reset_state: got %0d need %0d", dut.state, HUNT);
    end
  endtask

  task automatic test_ramp();
    step(1'b1, 1'b0, 3'b000);
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b1, gtab[i % 8]);
      n_cmp++;
      if (Bin_out !== 3'(i % 8) || Out_valid !== 1'b1 || Locked !== 1'b1 || Error !== 1'b0) begin
        n_fail++;
        $display("FAIL ramp_%0d: got bin=%0d ov=%b lk=%b err=%b, need bin=%0d ov=1 lk=1 err=0",
                 i, Bin_out, Out_valid, Locked, Error, i % 8);
      end
    end
    n_cmp++;
    if (Wraps !== 4'd1) begin
      n_fail++;
      $display("FAIL ramp_wraps: got %0d need 1", Wraps);
    end
    step(1'b0, 1'b0, 3'b000);
    n_cmp++;
    if (Out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ramp_pulse_end: got ov=%b need 0", Out_valid);
    end
  endtask

  task automatic test_hold_gaps();
    step(1'b1, 1'b0, 3'b000);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 3'b011);
      n_cmp++;
      if (Bin_out !== 3'd2 || Out_valid !== 1'b1 || Error !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_%0d: got bin=%0d ov=%b err=%b, need bin=2 ov=1 err=0",
                 k, Bin_out, Out_valid, Error);
      end
      step(1'b0, 1'b0, 3'b110);
      n_cmp++;
      if (Out_valid !== 1'b0 || Bin_out !== 3'd2) begin
        n_fail++;
        $display("FAIL gap_%0d: got ov=%b bin=%0d, need ov=0 bin=2", k, Out_valid, Bin_out);
      end
    end
    step(1'b0, 1'b1, 3'b010);
    n_cmp++;
    if (Bin_out !== 3'd3 || Out_valid !== 1'b1 || Error !== 1'b0 || Locked !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_advance: got bin=%0d ov=%b err=%b lk=%b, need 3 1 0 1",
               Bin_out, Out_valid, Error, Locked);
    end
  endtask

  task automatic test_illegal();
    step(1'b1, 1'b0, 3'b000);
    step(1'b0, 1'b1, 3'b001);
    n_cmp++;
    if (Bin_out !== 3'd1 || Locked !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_lock: got bin=%0d lk=%b, need 1 1", Bin_out, Locked);
    end
    step(1'b0, 1'b1, 3'b110);
    n_cmp++;
    if (Error !== 1'b1 || Locked !== 1'b0 || Bin_out !== 3'd1 || Out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_step: got err=%b lk=%b bin=%0d ov=%b, need 1 0 1 0",
               Error, Locked, Bin_out, Out_valid);
    end
    step(1'b0, 1'b1, 3'b011);
    n_cmp++;
    if (Error !== 1'b1 || Locked !== 1'b0 || Bin_out !== 3'd1 || Out_valid !== 1'b0 ||
        Wraps !== 4'd0) begin
      n_fail++;
      $display("FAIL fault_frozen: got err=%b lk=%b bin=%0d ov=%b wraps=%0d, need 1 0 1 0 0",
               Error, Locked, Bin_out, Out_valid, Wraps);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b1, 3'b101);
    n_cmp++;
    if (Bin_out !== 3'd0 || Out_valid !== 1'b0 || Wraps !== 4'd0 ||
        Locked !== 1'b0 || Error !== 1'b0 || dut.state !== HUNT) begin
      n_fail++;
      $display("FAIL reset_mid: got bin=%0d ov=%b wraps=%0d lk=%b err=%b st=%0d, need all 0",
               Bin_out, Out_valid, Wraps, Locked, Error, dut.state);
    end
    step(1'b0, 1'b1, 3'b101);
    n_cmp++;
    if (Bin_out !== 3'd6 || Out_valid !== 1'b1 || Locked !== 1'b1 || Wraps !== 4'd0 ||
        Error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rebase: got bin=%0d ov=%b lk=%b wraps=%0d err=%b, need 6 1 1 0 0",
               Bin_out, Out_valid, Locked, Wraps, Error);
    end
  endtask

  task automatic test_wrap_sat();
    int exp_wraps;
    step(1'b1, 1'b0, 3'b000);
    exp_wraps = 0;
    for (int lp = 0; lp < 17; lp++) begin
      for (int i = 0; i < 8; i++) begin
        step(1'b0, 1'b1, gtab[i]);
        if (i == 0 && lp > 0 && exp_wraps < 15) exp_wraps++;
      end
      if (lp == 15) begin
        n_cmp++;
        if (Wraps !== 4'(exp_wraps) || exp_wraps != 15) begin
          n_fail++;
          $display("FAIL wrap_at_15: got %0d need 15", Wraps);
        end
      end
    end
    step(1'b0, 1'b1, 3'b000);
    n_cmp++;
    if (Wraps !== 4'd15 || Error !== 1'b0 || Bin_out !== 3'd0 || Out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_saturate: got wraps=%0d err=%b bin=%0d ov=%b, need 15 0 0 1",
               Wraps, Error, Bin_out, Out_valid);
    end
  endtask

  task automatic test_hunt_base();
    step(1'b1, 1'b0, 3'b000);
    step(1'b0, 1'b1, 3'b100);
    n_cmp++;
    if (Bin_out !== 3'd7 || Wraps !== 4'd0 || Locked !== 1'b1) begin
      n_fail++;
      $display("FAIL hunt_base7: got bin=%0d wraps=%0d lk=%b, need 7 0 1", Bin_out, Wraps, Locked);
    end
    step(1'b0, 1'b1, 3'b000);
    n_cmp++;
    if (Bin_out !== 3'd0 || Wraps !== 4'd1 || Error !== 1'b0) begin
      n_fail++;
      $display("FAIL hunt_base_wrap: got bin=%0d wraps=%0d err=%b, need 0 1 0", Bin_out, Wraps, Error);
    end
    step(1'b1, 1'b0, 3'b000);
    step(1'b0, 1'b1, 3'b000);
    n_cmp++;
    if (Bin_out !== 3'd0 || Wraps !== 4'd0 || Locked !== 1'b1 || Out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL hunt_zero_first: got bin=%0d wraps=%0d lk=%b ov=%b, need 0 0 1 1",
               Bin_out, Wraps, Locked, Out_valid);
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    Reset    = 1'b1;
    In_valid = 1'b0;
    Gray_in  = 3'b000;
    gtab[0] = 3'b000; gtab[1] = 3'b001; gtab[2] = 3'b011; gtab[3] = 3'b010;
    gtab[4] = 3'b110; gtab[5] = 3'b111; gtab[6] = 3'b101; gtab[7] = 3'b100;

    test_reset();
    test_ramp();
    test_hold_gaps();
    test_illegal();
    test_reset_mid();
    test_wrap_sat();
    test_hunt_base();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
